// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for register_file.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   REG_ZERO                : hard-wired zero register address
//   data_t / addr_t         : default-width data and address types
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  localparam addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port of the register file.
//   clk, rst_n    : clock, async active-low reset
//   mem_i         : flattened storage view from register_file
//   rd_addr_i     : read address, sampled on the rising edge
//   wr_en_i/wr_addr_i/wr_data_i : write port, present only when
//                   REGFILE_BYPASS_EN is defined (write-first collisions)
//   rd_data_o     : registered read data (1-cycle latency)
// The data (not the address) is captured at the edge, so the output
// holds between edges and a collision naturally returns the old value
// unless the bypass build forwards the incoming write.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem_i,
  input  logic [ADDR_W-1:0]             rd_addr_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                          wr_en_i,
  input  logic [ADDR_W-1:0]             wr_addr_i,
  input  logic [DATA_W-1:0]             wr_data_i,
`endif
  output logic [DATA_W-1:0]             rd_data_o
);

  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = mem_i[rd_addr_i];
    // Zero register wins over everything, including bypass.
    if (rd_addr_i == ADDR_W'(REG_ZERO)) begin
      rd_data_d = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_d = wr_data_i;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/register_file.sv
// register_file: 2R1W register file, register 0 hard-wired to zero.
//   clk, rst_n          : clock, async active-low reset (clears all state)
//   regWrite            : write enable
//   writeReg, writeData : write address / data
//   readReg1, readReg2  : read addresses
//   readData1, readData2: registered read data, 1-cycle latency
// Build option: define REGFILE_BYPASS_EN for write-first collisions;
// default build is read-first.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam int NUM_PORTS = 2;

  logic [DEPTH-1:0][DATA_W-1:0] mem_d, mem_q;
  logic                         wr_en;

  // Writes to the zero register are dropped here, so mem_q[0] stays 0.
  assign wr_en = regWrite && (writeReg != ADDR_W'(REG_ZERO));

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[writeReg] = writeData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data;

  assign rd_addr = {readReg2, readReg1};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_i     (mem_q),
      .rd_addr_i (rd_addr[p]),
`ifdef REGFILE_BYPASS_EN
      .wr_en_i   (wr_en),
      .wr_addr_i (writeReg),
      .wr_data_i (writeData),
`endif
      .rd_data_o (rd_data[p])
    );
  end

  assign readData1 = rd_data[0];
  assign readData2 = rd_data[1];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regWrite;
  logic [4:0]  writeReg, readReg1, readReg2;
  logic [31:0] writeData, readData1, readData2;

  int checks = 0;
  int errors = 0;

  register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .readData1 (readData1),
    .readData2 (readData2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    regWrite = 1'b1; writeReg = a; writeData = d;
    tick();
    regWrite = 1'b0;
  endtask

  initial begin
    logic [31:0] coll_exp;
    rst_n = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
    readReg1 = '0; readReg2 = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_rd1", readData1, 32'h0);
    chk("reset_rd2", readData2, 32'h0);
    #1 rst_n = 1'b1;

    // r5 written, read back, then async reset mid-cycle
    wr(5'd5, 32'hFFFF_FFFF);
    readReg1 = 5'd5; readReg2 = 5'd5;
    tick();
    chk("r5_pre_rst_rd1", readData1, 32'hFFFF_FFFF);
    chk("r5_pre_rst_rd2", readData2, 32'hFFFF_FFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rd1", readData1, 32'h0);
    chk("async_rst_rd2", readData2, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    chk("r5_after_rst", readData1, 32'h0);

    // write attempted while reset held is ignored
    rst_n = 1'b0;
    regWrite = 1'b1; writeReg = 5'd6; writeData = 32'h5555_5555;
    tick();
    chk("rst_hold_rd1", readData1, 32'h0);
    #2 rst_n = 1'b1; regWrite = 1'b0; readReg1 = 5'd6;
    tick();
    chk("r6_write_in_rst", readData1, 32'h0);

    // basic write then read, 1-cycle latency
    wr(5'd3, 32'hAAAA_AAAA);
    readReg1 = 5'd3;
    tick();
    chk("r3_read", readData1, 32'hAAAA_AAAA);

    // register 0
    wr(5'd0, 32'h1234_5678);
    readReg1 = 5'd0; readReg2 = 5'd0;
    tick();
    chk("r0_rd1", readData1, 32'h0);
    chk("r0_rd2", readData2, 32'h0);

    // r0 never bypasses: write r0 while reading r0
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'h9999_9999;
    tick();
    regWrite = 1'b0;
    chk("r0_no_bypass", readData1, 32'h0);

    // collision
    wr(5'd7, 32'h1111_1111);
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h2222_2222; readReg2 = 5'd7;
    tick();
    regWrite = 1'b0;
`ifdef REGFILE_BYPASS_EN
    coll_exp = 32'h2222_2222;
`else
    coll_exp = 32'h1111_1111;
`endif
    chk("collision_rd2", readData2, coll_exp);
    tick();
    chk("collision_next", readData2, 32'h2222_2222);

    // dual port
    wr(5'd1, 32'hDEAD_BEEF);
    wr(5'd2, 32'hCAFE_F00D);
    readReg1 = 5'd1; readReg2 = 5'd2;
    tick();
    chk("dual_rd1", readData1, 32'hDEAD_BEEF);
    chk("dual_rd2", readData2, 32'hCAFE_F00D);
    readReg1 = 5'd2;
    tick();
    chk("same_addr_rd1", readData1, 32'hCAFE_F00D);
    chk("same_addr_rd2", readData2, 32'hCAFE_F00D);

    // outputs hold between edges when address changes
    readReg1 = 5'd3;
    #2;
    chk("hold_between_edges", readData1, 32'hCAFE_F00D);

    // regWrite=0 with toggling data for 4 cycles
    writeReg = 5'd1;
    for (int i = 0; i < 4; i++) begin
      writeData = (i % 2 == 0) ? 32'h0F0F_0F0F : 32'hF0F0_F0F0;
      tick();
    end
    readReg1 = 5'd1; readReg2 = 5'd2;
    tick();
    chk("hold_r1", readData1, 32'hDEAD_BEEF);
    chk("hold_r2", readData2, 32'hCAFE_F00D);
    readReg1 = 5'd3; readReg2 = 5'd7;
    tick();
    chk("hold_r3", readData1, 32'hAAAA_AAAA);
    chk("hold_r7", readData2, 32'h2222_2222);

    // back-to-back writes to same address
    wr(5'd9, 32'h0000_0001);
    wr(5'd9, 32'h0000_0002);
    readReg1 = 5'd9; readReg2 = 5'd31;
    tick();
    chk("b2b_r9", readData1, 32'h0000_0002);
    chk("r31_untouched", readData2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
